// File: rtl/jtkicker_pkg.sv
// Shared types for the Kicker ROM arbiter: FSM encoding and grant identifiers.
package jtkicker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic GNT_SCR = 1'b0;
    localparam logic GNT_OBJ = 1'b1;

endpackage

// File: rtl/jtkicker_romarb_slot.sv
// One requester slot: latches the granted address, captures SDRAM data and
// keeps the valid flag that says the data still belongs to the live request.
module jtkicker_romarb_slot #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          latch_i,     // grant: remember the requested address
    input  logic          cap_i,       // SDRAM data for this slot is on sd_data_i
    input  logic [31:0]   sd_data_i,
    output logic [31:0]   data_o,
    output logic          ok_o,
    output logic          pend_o
);

    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic          valid_q;
    logic          match;

    assign match  = (addr_i == addr_q);
    assign ok_o   = valid_q & cs_i & match;
    // A live request with no valid data for its current address still needs a fetch.
    assign pend_o = cs_i & ~ok_o;
    assign data_o = data_q;

    // Address latch, data capture and valid tracking; a capture only validates
    // the data if the request is still asking for the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (latch_i) begin
                addr_q <= addr_i;
            end
            if (cap_i) begin
                data_q  <= sd_data_i;
                valid_q <= cs_i & match;
            end else if (!cs_i || !match) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtkicker_romarb.sv
// Two-requester SDRAM arbiter for tile (scr) and object (obj) ROM fetches.
// Objects win during blanking or after starving; otherwise tiles win ties.
//
// Handshake: a requester holds x_cs with a stable x_addr; x_ok rises when
// x_data holds the word for that address and stays high while cs and the
// address are unchanged. Toward the SDRAM, sd_cs is held with a stable
// sd_addr until sd_ok is sampled (not earlier than the second cycle of
// sd_cs), after which sd_cs drops for at least two cycles.
module jtkicker_romarb
    import jtkicker_pkg::*;
#(
    parameter int AW      = 13,
    parameter int MAXWAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LHBL,
    input  logic          scr_cs,
    input  logic [AW-1:0] scr_addr,
    output logic [31:0]   scr_data,
    output logic          scr_ok,
    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic [31:0]   obj_data,
    output logic          obj_ok,
    output logic          sd_cs,
    output logic [AW-1:0] sd_addr,
    input  logic [31:0]   sd_data,
    input  logic          sd_ok,
    output state_t        st_dbg
);

    localparam int SW = $clog2(MAXWAIT + 1);
    localparam logic [SW-1:0] MAXW = SW'(MAXWAIT);

    state_t        state_q;
    logic          gnt_q;
    logic          armed_q;
    logic          sd_cs_q;
    logic [AW-1:0] sd_addr_q;
    logic [SW-1:0] starve_q, starve_d;

    logic scr_pend, obj_pend;
    logic obj_win, scr_win;
    logic gnt_scr, gnt_obj;
    logic honour, cap_scr, cap_obj;
    logic obj_busy;

    assign sd_cs   = sd_cs_q;
    assign sd_addr = sd_addr_q;
    assign st_dbg  = state_q;

    jtkicker_romarb_slot #(.AW(AW)) u_scr (
        .clk       (clk),
        .rst       (rst),
        .cs_i      (scr_cs),
        .addr_i    (scr_addr),
        .latch_i   (gnt_scr),
        .cap_i     (cap_scr),
        .sd_data_i (sd_data),
        .data_o    (scr_data),
        .ok_o      (scr_ok),
        .pend_o    (scr_pend)
    );

    jtkicker_romarb_slot #(.AW(AW)) u_obj (
        .clk       (clk),
        .rst       (rst),
        .cs_i      (obj_cs),
        .addr_i    (obj_addr),
        .latch_i   (gnt_obj),
        .cap_i     (cap_obj),
        .sd_data_i (sd_data),
        .data_o    (obj_data),
        .ok_o      (obj_ok),
        .pend_o    (obj_pend)
    );

    // Arbitration decision, SDRAM completion and starvation counter next value.
    always_comb begin
        obj_win  = obj_pend & ((starve_q >= MAXW) | ~LHBL | ~scr_pend);
        scr_win  = scr_pend & ~obj_win;
        gnt_obj  = (state_q == ST_IDLE) & obj_win;
        gnt_scr  = (state_q == ST_IDLE) & scr_win;
        // sd_ok on the first edge of sd_cs is too early to be real data.
        honour   = (state_q == ST_BUSY) & armed_q & sd_ok;
        cap_scr  = honour & (gnt_q == GNT_SCR);
        cap_obj  = honour & (gnt_q == GNT_OBJ);
        obj_busy = (state_q != ST_IDLE) & (gnt_q == GNT_OBJ);

        starve_d = starve_q;
        if (gnt_obj) begin
            starve_d = '0;
        end else if (obj_pend && !obj_busy && starve_q < MAXW) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Arbiter FSM with registered SDRAM request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_SCR;
            armed_q   <= 1'b0;
            sd_cs_q   <= 1'b0;
            sd_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    armed_q <= 1'b0;
                    if (gnt_obj || gnt_scr) begin
                        gnt_q     <= gnt_obj ? GNT_OBJ : GNT_SCR;
                        sd_addr_q <= gnt_obj ? obj_addr : scr_addr;
                        sd_cs_q   <= 1'b1;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    armed_q <= 1'b1;
                    if (honour) begin
                        armed_q <= 1'b0;
                        sd_cs_q <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    sd_cs_q <= 1'b0;
                    armed_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles a pending object fetch has been passed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Directed bench for jtkicker_romarb: per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_jtkicker_romarb;
  import jtkicker_pkg::*;

  localparam int AW = 13;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          LHBL = 1'b1;
  logic          scr_cs = 1'b0;
  logic [AW-1:0] scr_addr = '0;
  logic [31:0]   scr_data;
  logic          scr_ok;
  logic          obj_cs = 1'b0;
  logic [AW-1:0] obj_addr = '0;
  logic [31:0]   obj_data;
  logic          obj_ok;
  logic          sd_cs;
  logic [AW-1:0] sd_addr;
  logic [31:0]   sd_data = '0;
  logic          sd_ok = 1'b0;
  state_t        st_dbg;

  jtkicker_romarb #(.AW(AW), .MAXWAIT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .LHBL     (LHBL),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .sd_cs    (sd_cs),
    .sd_addr  (sd_addr),
    .sd_data  (sd_data),
    .sd_ok    (sd_ok),
    .st_dbg   (st_dbg)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sd_cs(input string name);
    for (int i = 0; i < 16; i++) begin
      if (sd_cs) break;
      tick();
    end
    chk({name, "_sd_cs_rise"}, {31'd0, sd_cs}, 32'd1);
  endtask

  // Called right after sd_cs rose: one quiet cycle, then sd_ok with data.
  task automatic serve(input string name, input logic [AW-1:0] addr, input logic [31:0] data);
    tick();
    chk({name, "_addr_stable"}, 32'(sd_addr), 32'(addr));
    sd_ok = 1'b1;
    sd_data = data;
    tick();
    sd_ok = 1'b0;
    sd_data = '0;
    chk({name, "_sd_cs_drop"}, {31'd0, sd_cs}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scr_cs = 1'b0;
    obj_cs = 1'b0;
    sd_ok = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // per-cycle vector table
  typedef struct {
    logic          rst;
    logic          lhbl;
    logic          scr_cs;
    logic [AW-1:0] scr_addr;
    logic          obj_cs;
    logic [AW-1:0] obj_addr;
    logic          sd_ok;
    logic [31:0]   sd_data;
    logic          e_sd_cs;
    logic [AW-1:0] e_sd_addr;
    logic          e_scr_ok;
    logic [31:0]   e_scr_data;
    logic          e_obj_ok;
    logic [31:0]   e_obj_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [AW-1:0] a;
    int grant_idx;
    int obj_at;

    // rst lhbl scs saddr ocs oaddr sdok sddata | sdcs sdaddr sok sdata ook odata
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 13'h0000, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b0, 13'h0000, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 13'h0123, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b1, 13'h0123, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 13'h0123, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b1, 13'h0123, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 13'h0123, 1'b0, 13'h0, 1'b1, 32'hDEADBEEF,
                 1'b0, 13'h0123, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 13'h0123, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b0, 13'h0123, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 13'h0123, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b0, 13'h0123, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 13'h0123, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b0, 13'h0123, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 13'h0200, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b1, 13'h0200, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 13'h0200, 1'b0, 13'h0, 1'b1, 32'h11111111,
                 1'b1, 13'h0200, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 13'h0200, 1'b0, 13'h0, 1'b1, 32'h22222222,
                 1'b0, 13'h0200, 1'b1, 32'h22222222, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 13'h0200, 1'b0, 13'h0, 1'b0, 32'h0,
                 1'b0, 13'h0200, 1'b0, 32'h22222222, 1'b0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      LHBL = vecs[i].lhbl;
      scr_cs = vecs[i].scr_cs;
      scr_addr = vecs[i].scr_addr;
      obj_cs = vecs[i].obj_cs;
      obj_addr = vecs[i].obj_addr;
      sd_ok = vecs[i].sd_ok;
      sd_data = vecs[i].sd_data;
      tick();
      chk($sformatf("v%0d_sd_cs", i), {31'd0, sd_cs}, {31'd0, vecs[i].e_sd_cs});
      chk($sformatf("v%0d_sd_addr", i), 32'(sd_addr), 32'(vecs[i].e_sd_addr));
      chk($sformatf("v%0d_scr_ok", i), {31'd0, scr_ok}, {31'd0, vecs[i].e_scr_ok});
      chk($sformatf("v%0d_scr_data", i), scr_data, vecs[i].e_scr_data);
      chk($sformatf("v%0d_obj_ok", i), {31'd0, obj_ok}, {31'd0, vecs[i].e_obj_ok});
      chk($sformatf("v%0d_obj_data", i), obj_data, vecs[i].e_obj_data);
    end
    sd_ok = 1'b0;
    sd_data = '0;

    // tie during active line: scr first, then obj
    do_reset();
    LHBL = 1'b1;
    scr_cs = 1'b1; scr_addr = 13'h0010;
    obj_cs = 1'b1; obj_addr = 13'h0040;
    exp_q.push_back(13'h0010);
    exp_q.push_back(13'h0040);
    wait_sd_cs("tie1");
    a = exp_q.pop_front();
    chk("tie1_addr", 32'(sd_addr), 32'(a));
    serve("tie1", a, 32'hA0A0A0A0);
    chk("tie1_scr_ok", {31'd0, scr_ok}, 32'd1);
    chk("tie1_scr_data", scr_data, 32'hA0A0A0A0);
    chk("tie1_obj_ok", {31'd0, obj_ok}, 32'd0);
    wait_sd_cs("tie2");
    a = exp_q.pop_front();
    chk("tie2_addr", 32'(sd_addr), 32'(a));
    serve("tie2", a, 32'hB1B1B1B1);
    chk("tie2_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("tie2_obj_data", obj_data, 32'hB1B1B1B1);
    chk("tie2_scr_held", {31'd0, scr_ok}, 32'd1);

    // blanking: obj first, then scr
    do_reset();
    LHBL = 1'b0;
    scr_cs = 1'b1; scr_addr = 13'h0010;
    obj_cs = 1'b1; obj_addr = 13'h0040;
    exp_q.push_back(13'h0040);
    exp_q.push_back(13'h0010);
    wait_sd_cs("blk1");
    a = exp_q.pop_front();
    chk("blk1_addr", 32'(sd_addr), 32'(a));
    serve("blk1", a, 32'hC2C2C2C2);
    chk("blk1_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("blk1_obj_data", obj_data, 32'hC2C2C2C2);
    wait_sd_cs("blk2");
    a = exp_q.pop_front();
    chk("blk2_addr", 32'(sd_addr), 32'(a));
    serve("blk2", a, 32'hD3D3D3D3);
    chk("blk2_scr_ok", {31'd0, scr_ok}, 32'd1);
    chk("blk2_scr_data", scr_data, 32'hD3D3D3D3);

    // starvation: scr keeps asking for new addresses, obj must still get in.
    // Each scr transaction spans 4 edges, so starve reaches 8 after two.
    do_reset();
    LHBL = 1'b1;
    scr_cs = 1'b1; scr_addr = 13'h0100;
    obj_cs = 1'b1; obj_addr = 13'h0060;
    obj_at = 0;
    grant_idx = 0;
    for (int t = 0; t < 6; t++) begin
      wait_sd_cs("stv");
      grant_idx++;
      if (sd_addr == 13'h0060) begin
        obj_at = grant_idx;
        break;
      end
      serve("stv_scr", sd_addr, 32'h5C000000 + grant_idx);
      scr_addr = scr_addr + 13'd1;
    end
    chk("stv_obj_grant_by_3", {31'd0, (obj_at >= 1 && obj_at <= 3)}, 32'd1);
    serve("stv_obj", 13'h0060, 32'h0B0B0B0B);
    chk("stv_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("stv_obj_data", obj_data, 32'h0B0B0B0B);

    // address change while obj is in flight
    do_reset();
    LHBL = 1'b1;
    obj_cs = 1'b1; obj_addr = 13'h0040;
    wait_sd_cs("chg1");
    chk("chg1_addr", 32'(sd_addr), 32'h0040);
    tick();
    obj_addr = 13'h0041;
    #1;
    chk("chg_busy_obj_ok", {31'd0, obj_ok}, 32'd0);
    sd_ok = 1'b1; sd_data = 32'hEEEE0040;
    tick();
    sd_ok = 1'b0; sd_data = '0;
    chk("chg_discard_obj_ok", {31'd0, obj_ok}, 32'd0);
    chk("chg_discard_sd_cs", {31'd0, sd_cs}, 32'd0);
    wait_sd_cs("chg2");
    chk("chg2_addr", 32'(sd_addr), 32'h0041);
    serve("chg2", 13'h0041, 32'hEEEE0041);
    chk("chg2_obj_ok", {31'd0, obj_ok}, 32'd1);
    chk("chg2_obj_data", obj_data, 32'hEEEE0041);

    // reset during BUSY, then a late sd_ok
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0077;
    wait_sd_cs("rstb");
    rst = 1'b1;
    scr_cs = 1'b0;
    tick();
    chk("rstb_sd_cs", {31'd0, sd_cs}, 32'd0);
    rst = 1'b0;
    sd_ok = 1'b1; sd_data = 32'h55555555;
    tick();
    sd_ok = 1'b0; sd_data = '0;
    tick();
    chk("rstb_scr_ok", {31'd0, scr_ok}, 32'd0);
    chk("rstb_scr_data", scr_data, 32'h0);
    chk("rstb_obj_data", obj_data, 32'h0);
    chk("rstb_sd_cs_late", {31'd0, sd_cs}, 32'd0);
    chk("rstb_sd_addr", 32'(sd_addr), 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtkicker_romarb.md
JTKICKER_ROMARB -- requirements
Module: jtkicker_romarb

Interface
REQ-001 SHALL have parameter AW, default 13: requester and SDRAM address width.
REQ-002 SHALL have parameter MAXWAIT, default 8: cycles an object request may be refused before it is forced to win.
REQ-003 SHALL have clk, input, 1: single system clock (48 MHz); all logic on its rising edge.
REQ-004 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have LHBL, input, 1: horizontal blank, active low; high means active line.
REQ-006 SHALL have scr_cs, input, 1: tile-fetch request; scr_addr, input, AW: tile-fetch address.
REQ-007 SHALL have scr_data, output, 32: tile data; scr_ok, output, 1: tile data valid.
REQ-008 SHALL have obj_cs, input, 1: object-fetch request; obj_addr, input, AW: object-fetch address.
REQ-009 SHALL have obj_data, output, 32: object data; obj_ok, output, 1: object data valid.
REQ-010 SHALL have sd_cs, output, 1: SDRAM request; sd_addr, output, AW: SDRAM address.
REQ-011 SHALL have sd_data, input, 32: SDRAM data; sd_ok, input, 1: SDRAM data valid.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-013 In IDLE, a requester is pending when its cs=1 and it does not already hold valid data for its current address.
REQ-014 In IDLE, obj SHALL win when obj is pending and any of these holds: starve>=MAXWAIT, LHBL=0, or scr not pending; otherwise a pending scr wins.
REQ-015 On a grant, the block SHALL latch the winner's address and id, set sd_cs=1 and sd_addr to the latched address on the next edge, and enter BUSY.
REQ-016 sd_addr SHALL stay stable while sd_cs=1.
REQ-017 In BUSY, sd_ok SHALL be honoured only from the cycle after sd_cs rose.
REQ-018 When sd_ok is honoured, the block SHALL capture sd_data into the winner's data register, clear sd_cs, and enter DONE.
REQ-019 If the winner's cs is still high and its address still equals the latched address at capture, the block SHALL set that requester's valid flag.
REQ-020 If the winner's cs dropped or its address changed during BUSY, the SDRAM transaction SHALL still complete, the data SHALL be discarded with valid left clear, and arbitration resumes in IDLE.
REQ-021 Each x_ok SHALL equal valid_x & x_cs & (x_addr==latched_x); it is combinational, so it drops in the same cycle cs falls or the address changes.
REQ-022 valid_x SHALL clear on the edge after x_cs=0 or x_addr differs from latched_x.
REQ-023 x_data SHALL hold its value until the next capture for that requester.
REQ-024 Latency: a request pending in IDLE at edge n SHALL give sd_cs=1 after edge n; sd_ok at edge m (m>n+1) SHALL give x_ok=1 after edge m.
REQ-025 starve SHALL be a saturating counter.
REQ-026 starve SHALL increment each cycle obj is pending and not granted, SHALL saturate at MAXWAIT, and SHALL clear on obj grant.
REQ-027 Tie case: both pending, LHBL=1 and starve<MAXWAIT SHALL give the grant to scr.
REQ-028 A requester already holding valid data SHALL never be re-granted.

Reset
REQ-029 On rst=1, state SHALL be IDLE, and sd_cs, sd_addr, scr_data, obj_data, both valid flags, starve and the latched addresses SHALL be 0.
REQ-030 A reset asserted during BUSY SHALL drop sd_cs on that edge.
REQ-031 After a reset during BUSY, a late sd_ok SHALL be ignored.

Structure
REQ-032 The state encoding (IDLE/BUSY/DONE) and the grant-id constants (GNT_SCR=0, GNT_OBJ=1) SHALL live in shared package jtkicker_pkg.
REQ-033 Per-requester latch, data, valid and address compare SHALL be one sub-module, jtkicker_romarb_slot, instantiated twice.

Verification
REQ-034 Single scr request: scr_cs=1, scr_addr=0x0123, sd_ok two cycles after sd_cs with sd_data=0xDEADBEEF -> sd_addr=0x0123; scr_ok=1 with scr_data=0xDEADBEEF one cycle after sd_ok; scr_ok held until scr_cs falls.
REQ-035 Tie during active line: both cs rise together, LHBL=1 -> scr served first, then obj; obj_ok follows second sd_ok.
REQ-036 Blanking priority: same as REQ-035 but LHBL=0 -> obj served first.
REQ-037 Starvation: LHBL=1, scr issues back-to-back new addresses, obj_cs held -> obj granted no later than its first IDLE after starve reaches 8.
REQ-038 Address change mid-flight: obj_addr changes 0x0040->0x0041 during BUSY -> obj_ok stays 0, second sd_cs with sd_addr=0x0041, then obj_ok=1.
REQ-039 Reset during BUSY: rst pulsed one cycle after sd_cs rises, sd_ok arrives later -> sd_cs=0 on the reset edge, no ok asserted, outputs 0.
